s2p_rx_frame: RTL and testbench

Parametrised framed serial-to-parallel receiver for the inter-board link between the two game consoles. It samples a serial line on a bit-rate strobe, detects start/stop framing, assembles DATA_W-bit words MSB-first, and queues them in a small FIFO. Words are delivered to the battle-logic controller over a valid/ready handshake, and the block flags framing and overflow errors.

---
 rtl/s2p_pkg.sv | 24 ++
 rtl/s2p_rx_frame_if.sv | 11 +
 rtl/s2p_fifo.sv | 45 ++++
 rtl/s2p_rx_frame.sv | 129 ++++++++++++
 tb/tb_s2p_rx_frame.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/s2p_pkg.sv
// Shared types, line constants and width helper for the framed serial receiver.
package s2p_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic IDLE_LINE = 1'b1;
  localparam logic START_BIT = 1'b0;

  // Ceiling log2; the loop has a fixed bound so it also elaborates as a constant.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/s2p_rx_frame_if.sv
// Output word handshake between the receiver (master) and the consumer (slave).
interface s2p_rx_frame_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/s2p_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push into a full FIFO is taken when a pop happens in the same cycle.
module s2p_fifo
  import s2p_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/s2p_rx_frame.sv
// Framed serial-to-parallel receiver: start bit, MSB-first data, optional even parity, stop bit.
// Define S2P_PARITY_EN to add the parity bit and its check.
module s2p_rx_frame
  import s2p_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bit_tick,
  input  logic                  rx_en,
  input  logic                  s_in,
  input  logic                  ovf_clr,
  output logic                  frame_err,
  output logic                  overflow,
  s2p_rx_frame_if.master        rx_out
);

  localparam int              CNT_W = clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              push, err_d, pop, ovf_set;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;
`ifdef S2P_PARITY_EN
  logic              par_bad_q, par_bad_d;
`endif

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    push    = 1'b0;
    err_d   = 1'b0;
`ifdef S2P_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    if (!rx_en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (bit_tick) begin
      case (state_q)
        IDLE: begin
          if (s_in == START_BIT) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shift_d = DATA_W'({shift_q, s_in});
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            cnt_d = '0;
`ifdef S2P_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
`ifdef S2P_PARITY_EN
        PARITY: begin
          par_bad_d = (s_in != ^shift_q);
          state_d   = STOP;
        end
`endif
        STOP: begin
`ifdef S2P_PARITY_EN
          push = (s_in == IDLE_LINE) && !par_bad_q;
`else
          push = (s_in == IDLE_LINE);
`endif
          err_d   = !push;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign pop     = rx_out.out_valid && rx_out.out_ready;
  assign ovf_set = push && fifo_full && !pop;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
`ifdef S2P_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      frame_err <= err_d;
      overflow  <= ovf_set || (overflow && !ovf_clr);
`ifdef S2P_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  s2p_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (shift_q),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign rx_out.out_valid = !fifo_empty;
  assign rx_out.out_data  = fifo_empty ? '1 : fifo_head;

endmodule

// File: tb/tb_s2p_rx_frame.sv
// Directed self-checking bench for s2p_rx_frame (DATA_W=8, DEPTH=4); adds the parity case when S2P_PARITY_EN is defined.
module tb_s2p_rx_frame;

  logic clk = 1'b0;
  logic reset, bit_tick, rx_en, s_in, ovf_clr;
  logic frame_err, overflow;
  logic slow;
  int   n_checks = 0;
  int   n_fails  = 0;

  s2p_rx_frame_if #(.DATA_W(8)) bus ();

  s2p_rx_frame #(.DATA_W(8), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bit_tick  (bit_tick),
    .rx_en     (rx_en),
    .s_in      (s_in),
    .ovf_clr   (ovf_clr),
    .frame_err (frame_err),
    .overflow  (overflow),
    .rx_out    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle 1ns past it before anything is sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One bit time; in slow mode a tick-less edge precedes the sampling edge.
  task automatic send_bit(input logic b);
    s_in = b;
    if (slow) begin
      bit_tick = 1'b0;
      step();
      bit_tick = 1'b1;
    end
    step();
  endtask

  // Start bit, data MSB first, plus the even-parity bit when enabled; stops before the stop bit.
  task automatic frame_body(input logic [7:0] d);
    send_bit(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
`ifdef S2P_PARITY_EN
    send_bit(^d);
`endif
  endtask

  task automatic send_frame(input logic [7:0] d);
    frame_body(d);
    send_bit(1'b1);
  endtask

  task automatic idle_bit();
    send_bit(1'b1);
  endtask

  initial begin
    reset = 1'b1; bit_tick = 1'b1; rx_en = 1'b1; s_in = 1'b1; ovf_clr = 1'b0;
    slow = 1'b0; bus.out_ready = 1'b0;
    step(); step();
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 32'hFF);
    check("rst_ferr", frame_err, 0);
    check("rst_ovf", overflow, 0);
    reset = 1'b0;
    idle_bit();

    // Good frame A5: valid rises right after the stop sample.
    frame_body(8'hA5);
    check("a5_before_stop", bus.out_valid, 0);
    send_bit(1'b1);
    check("a5_valid", bus.out_valid, 1);
    check("a5_data", bus.out_data, 32'hA5);
    check("a5_ferr", frame_err, 0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("a5_pop_valid", bus.out_valid, 0);
    check("a5_pop_data", bus.out_data, 32'hFF);

    // Bad stop bit on 3C: one-cycle frame_err, nothing queued.
    frame_body(8'h3C);
    send_bit(1'b0);
    check("3c_ferr_hi", frame_err, 1);
    check("3c_valid", bus.out_valid, 0);
    idle_bit();
    check("3c_ferr_lo", frame_err, 0);

    // Five back-to-back frames into a 4-deep FIFO.
    for (int i = 1; i <= 5; i++) send_frame(8'(i));
    check("ovf_set", overflow, 1);
    check("ovf_head", bus.out_data, 32'h01);
    ovf_clr = 1'b1;
    idle_bit();
    ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("ovf_pop_order", bus.out_data, i);
      step();
    end
    bus.out_ready = 1'b0;
    check("ovf_drained", bus.out_valid, 0);

    // Full FIFO plus push with simultaneous pop, across pointer wrap.
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i));
    frame_body(8'h14);
    bus.out_ready = 1'b1;
    send_bit(1'b1);
    bus.out_ready = 1'b0;
    check("wrap_no_ovf", overflow, 0);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("wrap_order", bus.out_data, 32'h10 + i);
      step();
    end
    bus.out_ready = 1'b0;
    check("wrap_empty", bus.out_valid, 0);

    // rx_en dropped after four data bits discards the partial word.
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    rx_en = 1'b0;
    send_bit(1'b0);
    rx_en = 1'b1;
    idle_bit();
    check("rxen_no_word", bus.out_valid, 0);
    check("rxen_no_ferr", frame_err, 0);
    send_frame(8'h7E);
    check("rxen_7e_ferr", frame_err, 0);
    check("rxen_7e_valid", bus.out_valid, 1);
    check("rxen_7e_data", bus.out_data, 32'h7E);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("rxen_7e_only", bus.out_valid, 0);

    // Slowed bit rate: edges without bit_tick must not sample the line.
    slow = 1'b1;
    send_frame(8'hC3);
    slow = 1'b0;
    check("slow_data", bus.out_data, 32'hC3);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("slow_empty", bus.out_valid, 0);

    // Reset mid-frame with two words queued and overflow set.
    for (int i = 0; i < 5; i++) send_frame(8'h50 + 8'(i));
    bus.out_ready = 1'b1;
    step(); step();
    bus.out_ready = 1'b0;
    check("pre_rst_ovf", overflow, 1);
    check("pre_rst_head", bus.out_data, 32'h52);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    reset = 1'b1;
    s_in = 1'b0;
    step();
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_data", bus.out_data, 32'hFF);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_ferr", frame_err, 0);
    reset = 1'b0;
    idle_bit();
    send_frame(8'h99);
    check("post_rst_data", bus.out_data, 32'h99);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

`ifdef S2P_PARITY_EN
    // Wrong parity on 81 (even parity bit should be 0): dropped, single frame_err.
    send_bit(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(bit'((8'h81 >> i) & 8'h01));
    send_bit(1'b1);
    send_bit(1'b1);
    check("par_ferr", frame_err, 1);
    check("par_dropped", bus.out_valid, 0);
    idle_bit();
    check("par_ferr_lo", frame_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
